// File: rtl/regfiles_pkg.sv
// Shared constants for the regfiles register file: default widths, register count, reset value.
package regfiles_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  function automatic int reg_cnt(input int aw);
    return 1 << aw;
  endfunction

  localparam int REG_CNT = reg_cnt(ADDR_W_DEF);
  localparam int unsigned RST_VAL = 0;

endpackage

// File: rtl/regfiles_wdec.sv
// Write-enable decoder: binary write address to one-hot register enable, gated by we.
// Purely combinational, zero latency; no flow control.
module regfiles_wdec
  import regfiles_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  output logic [(1 << ADDR_W)-1:0] wen
);

  always_comb begin
    wen = '0;
    if (we) begin
      wen[waddr] = 1'b1;
    end
  end

endmodule

// File: rtl/regfiles.sv
// 2**ADDR_W x DATA_W register file, one write port, two combinational read ports (0-cycle read, no backpressure).
// Optional macro ZERO_REG_EN hardwires register 0 to zero; default build keeps it as ordinary storage.
module regfiles
  import regfiles_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  localparam int NREG = reg_cnt(ADDR_W);

  logic [NREG-1:0]   wen;
  logic [NREG-1:0]   wen_eff;
  logic [DATA_W-1:0] mem [NREG];

  regfiles_wdec #(
    .ADDR_W (ADDR_W)
  ) u_wdec (
    .we    (we),
    .waddr (waddr),
    .wen   (wen)
  );

`ifdef ZERO_REG_EN
  // Register 0 never gets an enable, so it holds its reset value of zero forever.
  assign wen_eff = wen & {{(NREG-1){1'b1}}, 1'b0};
`else
  assign wen_eff = wen;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem[i] <= DATA_W'(RST_VAL);
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wen_eff[i]) begin
          mem[i] <= wdata;
        end
      end
    end
  end

  // No write bypass: a same-address write shows up only after the edge.
  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];

endmodule

// File: tb/tb_regfiles.sv
// Directed self-checking bench for regfiles; honours ZERO_REG_EN when defined.
module tb_regfiles;
  import regfiles_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  raddr1 = '0;
  logic [4:0]  raddr2 = '0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata1;
  logic [31:0] rdata2;

  int n_pass = 0;
  int n_total = 0;

  regfiles dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .waddr  (waddr),
    .wdata  (wdata),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [31:0] pat(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {8'hC3, b, ~b, 8'(i * 7)};
  endfunction

  function automatic logic [31:0] exp_at(input int a, input logic [31:0] v);
`ifdef ZERO_REG_EN
    if (a == 0) return 32'h0;
`endif
    return v;
  endfunction

  initial begin
    // Reset state
    #2;
    raddr1 = 5'd0;
    raddr2 = 5'd31;
    #1;
    chk("reset_rd1", rdata1, 32'h0);
    chk("reset_rd2", rdata2, 32'h0);

    @(negedge clk);
    rst = 1'b1;

    // Write address 0
    @(negedge clk);
    we = 1'b1; waddr = 5'd0; wdata = 32'h180174FA; raddr1 = 5'd0;
    @(posedge clk); #1;
    chk("wr_addr0", rdata1, exp_at(0, 32'h180174FA));

    // Write address 31
    @(negedge clk);
    waddr = 5'd31; wdata = 32'hFA180174; raddr2 = 5'd31;
    @(posedge clk); #1;
    chk("wr_addr31", rdata2, 32'hFA180174);
    chk("addr0_kept", rdata1, exp_at(0, 32'h180174FA));

    // we=0 holds
    @(negedge clk);
    we = 1'b0; waddr = 5'd31; wdata = 32'hDEADBEEF;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("we0_hold", rdata2, 32'hFA180174);
    end

    // Read-during-write on both ports, same address
    @(negedge clk);
    we = 1'b1; waddr = 5'd5; wdata = 32'hAAAA5555;
    @(negedge clk);
    raddr1 = 5'd5; raddr2 = 5'd5; wdata = 32'h12345678;
    #1;
    chk("rdw_old_rd1", rdata1, 32'hAAAA5555);
    chk("rdw_old_rd2", rdata2, 32'hAAAA5555);
    @(posedge clk); #1;
    chk("rdw_new_rd1", rdata1, 32'h12345678);
    chk("rdw_new_rd2", rdata2, 32'h12345678);

    // Mid-cycle async reset, and reset beats a write edge
    @(negedge clk);
    we = 1'b0; raddr2 = 5'd31;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_rd1", rdata1, 32'h0);
    chk("arst_rd2", rdata2, 32'h0);
    we = 1'b1; waddr = 5'd5; wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    chk("rst_blocks_wr", rdata1, 32'h0);
    @(negedge clk);
    we = 1'b0;
    rst = 1'b1;
    for (int a = 0; a < REG_CNT; a++) begin
      raddr1 = 5'(a);
      raddr2 = 5'(REG_CNT - 1 - a);
      #1;
      chk("post_rst_rd1", rdata1, 32'h0);
      chk("post_rst_rd2", rdata2, 32'h0);
    end

    // Unique pattern per address, no aliasing
    for (int a = 0; a < REG_CNT; a++) begin
      @(negedge clk);
      we = 1'b1; waddr = 5'(a); wdata = pat(a);
    end
    @(negedge clk);
    we = 1'b0;
    for (int a = 0; a < REG_CNT; a++) begin
      raddr1 = 5'(a);
      raddr2 = 5'(REG_CNT - 1 - a);
      #1;
      chk("pat_rd1", rdata1, exp_at(a, pat(a)));
      chk("pat_rd2", rdata2, exp_at(REG_CNT - 1 - a, pat(REG_CNT - 1 - a)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfiles.md
REGFILES -- requirements
Module: regfiles

Interface
REQ-001 Parameter DATA_W, default 32, width of each register and of data ports.
REQ-002 Parameter ADDR_W, default 5, address width; register count is 2**ADDR_W (32).
REQ-003 clk  input  1  single clock; all writes on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 we  input  1  write enable, active-high.
REQ-006 raddr1  input  ADDR_W  read port 1 address.
REQ-007 raddr2  input  ADDR_W  read port 2 address.
REQ-008 waddr  input  ADDR_W  write port address.
REQ-009 wdata  input  DATA_W  write data.
REQ-010 rdata1  output  DATA_W  contents of register raddr1.
REQ-011 rdata2  output  DATA_W  contents of register raddr2.

Function
REQ-012 The block SHALL hold 2**ADDR_W registers of DATA_W bits each.
REQ-013 On a rising clk edge with rst high and we=1, the block SHALL load wdata into register waddr; no other register changes.
REQ-014 With we=0, the block SHALL leave all registers unchanged.
REQ-015 Read ports SHALL be combinational: rdata1/rdata2 reflect the addressed register in the same cycle, with zero clock latency.
REQ-016 Both read ports SHALL be independent; raddr1==raddr2 returns the same value on both.
REQ-017 Read-during-write to the same address SHALL return the pre-edge (old) value until the edge; the new value appears immediately after the edge, with no bypass path.
REQ-018 All addresses 0..31 SHALL be fully writable and readable when ZERO_REG_EN is undefined; no address wrap or out-of-range case exists.

Reset
REQ-019 While rst=0, all registers SHALL be cleared to 0 asynchronously, without waiting for a clock edge.
REQ-020 While rst=0, rdata1 and rdata2 SHALL read 0 for every address.
REQ-021 While rst=0, writes SHALL be ignored regardless of we; reset SHALL win over a simultaneous write edge.
REQ-022 After rst deasserts, the first write SHALL take effect on the next rising edge with we=1.

Configuration
REQ-023 Macro ZERO_REG_EN: when defined, register 0 SHALL be hardwired to 0; writes to address 0 are discarded and reads of address 0 return 0.
REQ-024 Without ZERO_REG_EN, register 0 SHALL be an ordinary storage register (default build).

Structure
REQ-025 A shared package regfiles_pkg SHALL hold the DATA_W/ADDR_W defaults, the register count constant, and the reset value constant (0).
REQ-026 The write-enable decode SHALL be a sub-module regfiles_wdec (ADDR_W-to-2**ADDR_W one-hot, gated by we).
REQ-027 Storage and read multiplexers SHALL reside in regfiles itself.

Verification
REQ-028 rst=1, we=1, waddr=0, wdata=32'h180174FA, one edge, raddr1=0 -> rdata1=32'h180174FA (32'h0 with ZERO_REG_EN).
REQ-029 Then waddr=31, wdata=32'hFA180174, one edge, raddr2=31 -> rdata2=32'hFA180174; rdata1 still 32'h180174FA.
REQ-030 we=0, wdata=32'hDEADBEEF, waddr=31, several edges -> rdata2 stays 32'hFA180174.
REQ-031 Drive rst=0 mid-cycle, between edges -> rdata1=rdata2=0 immediately; after rst=1, all 32 addresses read 0.
REQ-032 raddr1=raddr2=waddr=5, wdata=32'h12345678, we=1: before edge both read old value; after edge both read 32'h12345678.
REQ-033 Write a unique pattern to each of addresses 0..31, then read back on both ports -> every address returns its own pattern, with no aliasing.
